// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop adds two WIDTH-bit
// operands and a carry-in over WIDTH clocks, with a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             c_nx;
    logic [WIDTH-1:0] sum_nx;

    always_comb begin
        s    = a_sr[0] ^ b_sr[0] ^ c;
        c_nx = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]));
    end

    // LSB is computed first and enters at the MSB, so after WIDTH shifts the
    // bits sit in natural order; WIDTH=1 has nothing to shift.
    if (WIDTH == 1) begin : g_one
        assign sum_nx = s;
    end else begin : g_multi
        assign sum_nx = {s, sum[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        c     <= cin;
                        sum   <= '0;
                        cout  <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum  <= sum_nx;
                    c    <= c_nx;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        cout  <= c_nx;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8 and WIDTH=1) with a result scoreboard.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one WIDTH=8 operation; if poke > 0, a stray start with other
    // operands is raised for one cycle at that RUN cycle index.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input int poke);
        int n;
        int nbusy;
        logic [8:0] exp;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back(9'(a) + 9'(b) + 9'(c));
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'h11; b8 = 8'h11; cin8 = 1'b1;
        n = 0; nbusy = 0;
        while (!done8 && n < 40) begin
            if (busy8) nbusy++;
            if (poke > 0 && n == poke) start8 = 1'b1;
            else start8 = 1'b0;
            n++;
            @(negedge clk);
            start8 = 1'b0;
        end
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_busycycles"}, nbusy, 8);
        chk({tag, "_busy_at_done"}, busy8, 0);
        exp = q8.pop_front();
        chk({tag, "_result"}, {cout8, sum8}, exp);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, done8, 0);
        chk({tag, "_idle_after"}, busy8, 0);
    endtask

    initial begin
        int n;
        logic [8:0] exp;
        logic [1:0] exp1;

        repeat (2) @(negedge clk);
        chk("reset_busy", busy8, 0);
        chk("reset_done", done8, 0);
        chk("reset_sum_cout", {cout8, sum8}, 0);
        rst_n = 1'b1;

        op8("zero", 8'h00, 8'h00, 1'b0, 0);
        op8("ff_01", 8'hFF, 8'h01, 1'b0, 0);
        op8("a5_5a_c", 8'hA5, 8'h5A, 1'b1, 0);
        op8("3c_0f", 8'h3C, 8'h0F, 1'b0, 0);
        op8("start_ignored", 8'h3C, 8'h0F, 1'b0, 2);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", busy8, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", busy8, 0);
        chk("async_done", done8, 0);
        chk("async_sum_cout", {cout8, sum8}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8) n++;
        end
        chk("no_done_after_abort", n, 0);
        op8("after_reset", 8'h12, 8'h34, 1'b1, 0);

        // Start held high: back-to-back operations
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h100);
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        q8.push_back(9'h080);
        n = 0;
        while (!done8 && n < 40) begin n++; @(negedge clk); end
        chk("b2b_first_latency", n, 8);
        exp = q8.pop_front();
        chk("b2b_first_result", {cout8, sum8}, exp);
        @(negedge clk);
        chk("b2b_done_drops", done8, 0);
        chk("b2b_restarted", busy8, 1);
        n = 1;
        while (!done8 && n < 40) begin n++; @(negedge clk); end
        start8 = 1'b0;
        chk("b2b_gap", n, 9);
        exp = q8.pop_front();
        chk("b2b_second_result", {cout8, sum8}, exp);
        @(negedge clk);
        chk("b2b_stopped", busy8, 0);
        chk("sb8_empty", q8.size(), 0);

        // WIDTH=1: registered full adder
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
            start1 = 1'b1;
            q1.push_back(2'(a1) + 2'(b1) + 2'(cin1));
            @(negedge clk);
            start1 = 1'b0;
            chk("w1_busy", busy1, 1);
            chk("w1_done_early", done1, 0);
            @(negedge clk);
            chk("w1_done", done1, 1);
            exp1 = q1.pop_front();
            chk($sformatf("w1_fa_%0d", i), {cout1, sum1}, exp1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
